// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Used by the interface, the winner-select block and the arbiter top.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [1:0] PORT_LD   = 2'd0;
  localparam logic [1:0] PORT_D    = 2'd1;
  localparam logic [1:0] PORT_F    = 2'd2;
  localparam logic [1:0] PORT_NONE = 2'd3;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester handshakes and the memory-array bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic [1:0]    grant_id;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  f_req, f_addr,
    input  mem_rdata,
    output ld_ack, d_ack, f_ack, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, grant_id
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output f_req, f_addr,
    output mem_rdata,
    input  ld_ack, d_ack, f_ack, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, grant_id
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: loader > data > fetch, unless a starved
// fetch is being forced through ahead of both.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ld_req,
  input  logic       d_req,
  input  logic       f_req,
  input  logic       starve_force,
  output logic [1:0] winner
);

  always_comb begin
    winner = PORT_NONE;
    if (f_req && starve_force) begin
      winner = PORT_F;
    end else if (ld_req) begin
      winner = PORT_LD;
    end else if (d_req) begin
      winner = PORT_D;
    end else if (f_req) begin
      winner = PORT_F;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises loader, data and fetch accesses onto the single-port memory,
// one transaction at a time, with a starvation guard for instruction fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MEM_LAT  = 1,
  parameter int MAX_SKIP = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_SKIP + 1);

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    owner_q;
  logic [1:0]    winner;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [LW-1:0] lat_q;
  logic [LW-1:0] lat_nxt;
  logic [SW-1:0] skip_q;
  logic          any_req;
  logic          starve_force;
  logic          lat_done;

  logic          mem_en_c;
  logic          mem_we_c;
  logic          ld_ack_c;
  logic          d_ack_c;
  logic          f_ack_c;
  logic          busy_c;
  logic [1:0]    grant_id_c;

  assign any_req      = bus.ld_req | bus.d_req | bus.f_req;
  assign starve_force = bus.f_req && (skip_q == SW'(MAX_SKIP));
  assign lat_nxt      = lat_q + LW'(1);
  assign lat_done     = (lat_nxt == LW'(MEM_LAT));

  mem_arb_pick u_pick (
    .ld_req       (bus.ld_req),
    .d_req        (bus.d_req),
    .f_req        (bus.f_req),
    .starve_force (starve_force),
    .winner       (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_en_c   = 1'b0;
    mem_we_c   = 1'b0;
    ld_ack_c   = 1'b0;
    d_ack_c    = 1'b0;
    f_ack_c    = 1'b0;
    busy_c     = 1'b1;
    grant_id_c = owner_q;
    case (state_q)
      IDLE: begin
        busy_c     = 1'b0;
        grant_id_c = PORT_NONE;
        if (any_req) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_c = 1'b1;
        mem_we_c = we_q;
        state_d  = we_q ? ACK : WAIT;
      end
      WAIT: begin
        if (lat_done) begin
          state_d = ACK;
        end
      end
      ACK: begin
        ld_ack_c = (owner_q == PORT_LD);
        d_ack_c  = (owner_q == PORT_D);
        f_ack_c  = (owner_q == PORT_F);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured at grant so requesters may change them later.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= PORT_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      skip_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            case (winner)
              PORT_LD: begin
                addr_q  <= bus.ld_addr;
                we_q    <= bus.ld_we;
                wdata_q <= bus.ld_wdata;
              end
              PORT_D: begin
                addr_q  <= bus.d_addr;
                we_q    <= bus.d_we;
                wdata_q <= bus.d_wdata;
              end
              default: begin
                addr_q  <= bus.f_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
              end
            endcase
          end
          if (!bus.f_req || winner == PORT_F) begin
            skip_q <= '0;
          end else if (skip_q != SW'(MAX_SKIP)) begin
            skip_q <= skip_q + SW'(1);
          end
        end
        ISSUE: lat_q <= '0;
        WAIT: begin
          lat_q <= lat_nxt;
          if (lat_done) begin
            rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ld_ack    = ld_ack_c;
  assign bus.d_ack     = d_ack_c;
  assign bus.f_ack     = f_ack_c;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_c;
  assign bus.grant_id  = grant_id_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1/MAX_SKIP=2
// and one with MEM_LAT=3, each backed by a behavioural memory array.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(10), .DW(32)) bus_a ();
  mem_port_arbiter_if #(.AW(10), .DW(32)) bus_b ();

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .MAX_SKIP(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .MAX_SKIP(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Memory models: read data is present only in the cycle MEM_LAT after mem_en.
  logic [31:0] mem_a [0:1023];
  logic [31:0] pipe_a;
  logic [31:0] mem_b [0:1023];
  logic [31:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    pipe_a <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr] : 32'h0;
  end
  assign bus_a.mem_rdata = pipe_a;

  always @(posedge clk) begin
    if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr] : 32'h0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_b.mem_rdata = pipe_b[2];

  task automatic idle_inputs();
    bus_a.ld_req = 0; bus_a.ld_we = 0; bus_a.ld_addr = '0; bus_a.ld_wdata = '0;
    bus_a.d_req  = 0; bus_a.d_we  = 0; bus_a.d_addr  = '0; bus_a.d_wdata  = '0;
    bus_a.f_req  = 0; bus_a.f_addr = '0;
    bus_b.ld_req = 0; bus_b.ld_we = 0; bus_b.ld_addr = '0; bus_b.ld_wdata = '0;
    bus_b.d_req  = 0; bus_b.d_we  = 0; bus_b.d_addr  = '0; bus_b.d_wdata  = '0;
    bus_b.f_req  = 0; bus_b.f_addr = '0;
  endtask

  task automatic drive_a(input logic [1:0] port, input logic val, input logic we,
                         input logic [9:0] addr, input logic [31:0] wdata);
    case (port)
      PORT_LD: begin bus_a.ld_req = val; bus_a.ld_we = we; bus_a.ld_addr = addr; bus_a.ld_wdata = wdata; end
      PORT_D:  begin bus_a.d_req = val; bus_a.d_we = we; bus_a.d_addr = addr; bus_a.d_wdata = wdata; end
      default: begin bus_a.f_req = val; bus_a.f_addr = addr; end
    endcase
  endtask

  task automatic drive_b(input logic [1:0] port, input logic val, input logic we,
                         input logic [9:0] addr, input logic [31:0] wdata);
    case (port)
      PORT_LD: begin bus_b.ld_req = val; bus_b.ld_we = we; bus_b.ld_addr = addr; bus_b.ld_wdata = wdata; end
      PORT_D:  begin bus_b.d_req = val; bus_b.d_we = we; bus_b.d_addr = addr; bus_b.d_wdata = wdata; end
      default: begin bus_b.f_req = val; bus_b.f_addr = addr; end
    endcase
  endtask

  function automatic logic ack_a(input logic [1:0] port);
    case (port)
      PORT_LD: return bus_a.ld_ack;
      PORT_D:  return bus_a.d_ack;
      default: return bus_a.f_ack;
    endcase
  endfunction

  function automatic logic ack_b(input logic [1:0] port);
    case (port)
      PORT_LD: return bus_b.ld_ack;
      PORT_D:  return bus_b.d_ack;
      default: return bus_b.f_ack;
    endcase
  endfunction

  // One request from cycle 0; lat is the ack cycle, -1 if none within 20 cycles.
  task automatic xfer_a(input logic [1:0] port, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    @(negedge clk);
    drive_a(port, 1'b1, we, addr, wdata);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (ack_a(port)) begin
        lat = c;
        rd  = bus_a.rdata;
      end
    end
    drive_a(port, 1'b0, we, addr, wdata);
  endtask

  task automatic xfer_b(input logic [1:0] port, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    @(negedge clk);
    drive_b(port, 1'b1, we, addr, wdata);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (ack_b(port)) begin
        lat = c;
        rd  = bus_b.rdata;
      end
    end
    drive_b(port, 1'b0, we, addr, wdata);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus_a.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_a.busy); end
    vectors++;
    if (bus_a.grant_id !== PORT_NONE) begin miscompares++; $display("[TB] FAIL reset_grant: got %0d expected 3", bus_a.grant_id); end
    vectors++;
    if ({bus_a.mem_en, bus_a.mem_we} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_strobes: got %b expected 00", {bus_a.mem_en, bus_a.mem_we}); end
    vectors++;
    if ({bus_a.ld_ack, bus_a.d_ack, bus_a.f_ack} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_acks: got %b expected 000", {bus_a.ld_ack, bus_a.d_ack, bus_a.f_ack}); end
    vectors++;
    if (bus_a.rdata !== 32'h0 || bus_a.mem_addr !== 10'h0 || bus_a.mem_wdata !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_regs: got rdata %h addr %h wdata %h expected all 0", bus_a.rdata, bus_a.mem_addr, bus_a.mem_wdata);
    end
    vectors++;
    if (bus_b.busy !== 1'b0 || bus_b.grant_id !== PORT_NONE) begin miscompares++; $display("[TB] FAIL reset_b: got busy %b grant %0d expected 0/3", bus_b.busy, bus_b.grant_id); end
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_fetch_read();
    int          lat;
    logic [31:0] rd;
    logic        exp_en;
    logic        exp_ack;
    logic [1:0]  exp_gid;
    xfer_a(PORT_LD, 1'b1, 10'd5, 32'h0000_1234, lat, rd);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL ld_write_latency: got %0d expected 2", lat); end
    @(negedge clk);
    drive_a(PORT_F, 1'b1, 1'b0, 10'd5, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_en  = (c == 1);
      exp_ack = (c == 3);
      exp_gid = (c <= 3) ? PORT_F : PORT_NONE;
      vectors++;
      if (bus_a.mem_en !== exp_en) begin miscompares++; $display("[TB] FAIL fetch_mem_en c%0d: got %b expected %b", c, bus_a.mem_en, exp_en); end
      vectors++;
      if (bus_a.f_ack !== exp_ack) begin miscompares++; $display("[TB] FAIL fetch_ack c%0d: got %b expected %b", c, bus_a.f_ack, exp_ack); end
      vectors++;
      if (bus_a.grant_id !== exp_gid) begin miscompares++; $display("[TB] FAIL fetch_grant c%0d: got %0d expected %0d", c, bus_a.grant_id, exp_gid); end
      if (c == 3) begin
        vectors++;
        if (bus_a.rdata !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL fetch_rdata: got %h expected 00001234", bus_a.rdata); end
        drive_a(PORT_F, 1'b0, 1'b0, 10'd5, 32'h0);
      end
    end
  endtask

  task automatic test_data_write();
    int          lat;
    logic [31:0] rd;
    @(negedge clk);
    drive_a(PORT_D, 1'b1, 1'b1, 10'd1021, 32'hDEAD_BEEF);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (bus_a.mem_we !== (c == 1)) begin miscompares++; $display("[TB] FAIL write_mem_we c%0d: got %b expected %b", c, bus_a.mem_we, (c == 1)); end
      vectors++;
      if (bus_a.d_ack !== (c == 2)) begin miscompares++; $display("[TB] FAIL write_ack c%0d: got %b expected %b", c, bus_a.d_ack, (c == 2)); end
      if (c == 2) drive_a(PORT_D, 1'b0, 1'b0, 10'd0, 32'h0);
    end
    vectors++;
    if (bus_a.rdata !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL rdata_hold: got %h expected 00001234", bus_a.rdata); end
    xfer_a(PORT_D, 1'b0, 10'd1021, 32'h0, lat, rd);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("[TB] FAIL d_read_latency: got %0d expected 3", lat); end
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL d_read_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_simultaneous();
    int          lat;
    logic [31:0] rd;
    int          ld_c;
    int          d_c;
    int          f_c;
    int          multi;
    logic [31:0] ld_rd;
    logic [31:0] d_rd;
    logic [31:0] f_rd;
    ld_c = -1; d_c = -1; f_c = -1; multi = 0;
    ld_rd = '0; d_rd = '0; f_rd = '0;
    xfer_a(PORT_LD, 1'b1, 10'd100, 32'h1111_0000, lat, rd);
    xfer_a(PORT_LD, 1'b1, 10'd200, 32'h2222_0000, lat, rd);
    xfer_a(PORT_LD, 1'b1, 10'd300, 32'h3333_0000, lat, rd);
    @(negedge clk);
    drive_a(PORT_LD, 1'b1, 1'b0, 10'd100, 32'h0);
    drive_a(PORT_D,  1'b1, 1'b0, 10'd200, 32'h0);
    drive_a(PORT_F,  1'b1, 1'b0, 10'd300, 32'h0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (int'(bus_a.ld_ack) + int'(bus_a.d_ack) + int'(bus_a.f_ack) > 1) multi++;
      if (bus_a.ld_ack) begin ld_c = c; ld_rd = bus_a.rdata; drive_a(PORT_LD, 1'b0, 1'b0, 10'd0, 32'h0); end
      if (bus_a.d_ack)  begin d_c = c;  d_rd = bus_a.rdata;  drive_a(PORT_D,  1'b0, 1'b0, 10'd0, 32'h0); end
      if (bus_a.f_ack)  begin f_c = c;  f_rd = bus_a.rdata;  drive_a(PORT_F,  1'b0, 1'b0, 10'd0, 32'h0); end
    end
    vectors++;
    if (ld_c !== 3) begin miscompares++; $display("[TB] FAIL simul_ld_cycle: got %0d expected 3", ld_c); end
    vectors++;
    if (d_c !== 7) begin miscompares++; $display("[TB] FAIL simul_d_cycle: got %0d expected 7", d_c); end
    vectors++;
    if (f_c !== 11) begin miscompares++; $display("[TB] FAIL simul_f_cycle: got %0d expected 11", f_c); end
    vectors++;
    if (multi !== 0) begin miscompares++; $display("[TB] FAIL simul_multi_ack: got %0d cycles expected 0", multi); end
    vectors++;
    if ({ld_rd, d_rd, f_rd} !== {32'h1111_0000, 32'h2222_0000, 32'h3333_0000}) begin
      miscompares++; $display("[TB] FAIL simul_rdata: got %h %h %h expected 11110000 22220000 33330000", ld_rd, d_rd, f_rd);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] seq [6];
    logic [1:0] exp_seq [6];
    int         n;
    int         multi;
    int         first_f;
    n = 0; multi = 0; first_f = -1;
    exp_seq = '{PORT_D, PORT_D, PORT_F, PORT_D, PORT_D, PORT_F};
    for (int i = 0; i < 6; i++) seq[i] = PORT_NONE;
    @(negedge clk);
    drive_a(PORT_D, 1'b1, 1'b1, 10'd50, 32'h5A5A_0000);
    drive_a(PORT_F, 1'b1, 1'b0, 10'd300, 32'h0);
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(negedge clk);
      if (int'(bus_a.ld_ack) + int'(bus_a.d_ack) + int'(bus_a.f_ack) > 1) multi++;
      if (bus_a.d_ack) begin
        seq[n] = PORT_D;
        n++;
      end else if (bus_a.f_ack) begin
        seq[n] = PORT_F;
        n++;
        if (first_f < 0) first_f = c;
      end
    end
    drive_a(PORT_D, 1'b0, 1'b0, 10'd0, 32'h0);
    drive_a(PORT_F, 1'b0, 1'b0, 10'd0, 32'h0);
    vectors++;
    if (n !== 6) begin miscompares++; $display("[TB] FAIL starve_ack_count: got %0d expected 6", n); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (seq[i] !== exp_seq[i]) begin miscompares++; $display("[TB] FAIL starve_order[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]); end
    end
    vectors++;
    if (first_f !== 9) begin miscompares++; $display("[TB] FAIL starve_first_f: got %0d expected 9", first_f); end
    vectors++;
    if (multi !== 0) begin miscompares++; $display("[TB] FAIL starve_multi_ack: got %0d expected 0", multi); end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] rd;
    int          stray;
    stray = 0;
    @(negedge clk);
    drive_a(PORT_D, 1'b1, 1'b0, 10'd1021, 32'h0);
    repeat (2) @(negedge clk);
    vectors++;
    if (bus_a.busy !== 1'b1 || bus_a.grant_id !== PORT_D) begin
      miscompares++; $display("[TB] FAIL midrst_pre: got busy %b grant %0d expected 1/1", bus_a.busy, bus_a.grant_id);
    end
    rst_a = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus_a.busy !== 1'b0 || bus_a.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle: got busy %b mem_en %b expected 0/0", bus_a.busy, bus_a.mem_en); end
    vectors++;
    if (bus_a.grant_id !== PORT_NONE) begin miscompares++; $display("[TB] FAIL midrst_grant: got %0d expected 3", bus_a.grant_id); end
    vectors++;
    if (bus_a.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_rdata: got %h expected 0", bus_a.rdata); end
    if (bus_a.d_ack) stray++;
    rst_a = 1'b0;
    drive_a(PORT_D, 1'b0, 1'b0, 10'd0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      if (bus_a.ld_ack || bus_a.d_ack || bus_a.f_ack) stray++;
    end
    vectors++;
    if (stray !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_ack: got %0d acks expected 0", stray); end
    xfer_a(PORT_D, 1'b0, 10'd1021, 32'h0, lat, rd);
    vectors++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL midrst_reissue: got lat %0d data %h expected 3 deadbeef", lat, rd); end
  endtask

  task automatic test_long_latency();
    int          lat;
    logic [31:0] rd;
    xfer_b(PORT_LD, 1'b1, 10'd0, 32'hCAFE_F00D, lat, rd);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL lat3_write_latency: got %0d expected 2", lat); end
    xfer_b(PORT_F, 1'b0, 10'd0, 32'h0, lat, rd);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("[TB] FAIL lat3_fetch_latency: got %0d expected 5", lat); end
    vectors++;
    if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL lat3_fetch_data: got %h expected cafef00d", rd); end
    xfer_b(PORT_D, 1'b1, 10'd1023, 32'h0BAD_CAFE, lat, rd);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("[TB] FAIL lat3_d_write_latency: got %0d expected 2", lat); end
    xfer_b(PORT_D, 1'b0, 10'd1023, 32'h0, lat, rd);
    vectors++;
    if (lat !== 5 || rd !== 32'h0BAD_CAFE) begin miscompares++; $display("[TB] FAIL lat3_d_read: got lat %0d data %h expected 5 0badcafe", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_long_latency();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
